mips32_pipe_core: RTL and testbench
===================================

# mips32_pipe_core

Single-clock, parametrised successor to the team's two-phase five-stage MIPS32 pipeline (IF/ID/EX/MEM/WB) on the same opcode set. Adds asynchronous reset, configurable data and address widths, external instruction/data memory ports, hazard detection with load-use stall, optional operand forwarding, branch flush, and a retired-instruction counter. It is the CPU core instantiated under the SoC top and driven by the directed-program bench.

## Interface
- `XLEN`, 32: data and register width (16..64).
- `PC_W`, 10: word-address width of both memories.
- `RESET_PC`, 0: PC value after reset.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `imem_addr`  out  PC_W: fetch word address (= PC).
- `imem_rdata`  in  32: instruction; combinational read of `imem_addr`.
- `dmem_addr`  out  PC_W: data word address from EX/MEM ALU result `[PC_W-1:0]`.
- `dmem_wdata`  out  XLEN: store data.
- `dmem_we`  out  1: store strobe; memory writes on the rising edge while high.
- `dmem_rdata`  in  XLEN: load data; combinational read of `dmem_addr`.
- `halted`  out  1: sticky, set when HLT retires.
- `illegal`  out  1: sticky, set when an undefined opcode retires (treated as HLT).
- `instret`  out  32: count of retired non-bubble instructions; wraps at 2^32.

## Operation
- Encoding: op `[31:26]`, rs `[25:21]`, rt `[20:16]`, rd `[15:11]`, imm `[15:0]`, sign-extended to XLEN.
- Opcodes: ADD 000000, SUB 000001, AND 000010, OR 000011, SLT 000100, MUL 000101 (low XLEN bits), LW 001000, SW 001001, ADDI 001010, SUBI 001011, SLTI 001100, BNEQZ 001101, BEQZ 001110, HLT 111111.
- Destination: rd for register-register ops; rt for the immediate ops and LW. SLT/SLTI compare signed and write 1 or 0. r0 reads as 0 and ignores writes.
- Address: LW/SW at rs + imm. Branch target is NPC + imm, with NPC = PC+1. BEQZ is taken if rs == 0; BNEQZ is taken if rs != 0.
- Each stage register carries a valid bit. A bubble has valid=0 and no side effects.
- Register file reads rs and rt in ID. A write-back to the same register in the same cycle is bypassed into the read.
- Forwarding (macro on): EX operands take the EX/MEM ALU result first, then the MEM/WB result, then the ID/EX value. EX/MEM holding a LW is not forwarded.
- Load-use: ID needs a register that a LW in EX writes -> PC and IF/ID hold, and a bubble goes into ID/EX for 1 cycle.
- Branch is resolved in EX. If taken: PC <= target, IF/ID and ID/EX become bubbles (2-cycle penalty). If not taken: no penalty.
- HLT/illegal in ID freezes PC and fetch; IF/ID then supplies bubbles. Older instructions drain. `halted`/`illegal` set when it retires in WB; after that all stage registers freeze.
- A HLT flushed by a taken branch has no effect.

## Timing
- Reset values: PC=`RESET_PC`; all valid bits 0; all registers 0; `halted`=0, `illegal`=0, `instret`=0, `dmem_we`=0.
- Deassertion of `rst` takes effect at the next edge. Reset asserted mid-program aborts all in-flight instructions, including pending stores.
- An instruction fetched in cycle n writes back at the edge ending cycle n+4.
- `dmem_we` = valid SW in MEM.
- `instret` increments at the same edge as the write-back.
- Stall priority: a taken branch in EX overrides a load-use stall in the same cycle, so the stalled instruction is flushed.

## Configuration
- `PIPE_FWD_EN` defined: EX/MEM and MEM/WB forwarding plus the 1-cycle load-use stall.
- `PIPE_FWD_EN` undefined: no forwarding paths. ID stalls while any valid instruction in EX or MEM writes a non-zero register that ID reads; the WB bypass still applies. Results are identical; cycle counts are longer.

## Test plan
- ADDI r1,r0,10; ADDI r2,r0,20; ADD r3,r1,r2; HLT -> r3=30, `instret`=4. `halted` rises at cycle 8 with forwarding on, later with it off.
- SW r3,5(r0); LW r4,5(r0); ADD r5,r4,r4 -> dmem[5]=30, r5=60. Exactly one stall cycle with `PIPE_FWD_EN`.
- ADDI r1,r0,0; BEQZ r1,+2; ADDI r6,r0,1; ADDI r6,r0,2; ADDI r7,r0,3; HLT -> r6=0, r7=3. The two shadow instructions never write back.
- Factorial loop (r2=5, MUL/SUBI/BNEQZ) -> r3=120, loop exits, `halted`=1.
- Opcode 010101 mid-program -> `illegal`=1, `halted`=1. Earlier results are retained; no later instruction writes back.
- Assert `rst` mid-loop for 1 cycle -> all outputs at reset values, and execution restarts from `RESET_PC`.

Source files
------------

// File: rtl/mips32_pipe_core.sv
// mips32_pipe_core: five-stage (IF/ID/EX/MEM/WB) pipelined MIPS32-subset core.
//
// Parameters: XLEN (data width, 16..64), PC_W (word-address width of both
// memories), RESET_PC (PC after reset).
// Ports:
//   clk, rst         - single rising-edge clock, asynchronous active-high reset
//   imem_addr/rdata  - instruction fetch port (combinational read of PC)
//   dmem_addr/wdata/we/rdata - data memory port driven from the MEM stage
//   halted, illegal  - sticky status, set when HLT / an undefined opcode retires
//   instret          - count of retired non-bubble instructions (wraps)
// Build option: define PIPE_FWD_EN to enable EX/MEM and MEM/WB operand
// forwarding with a 1-cycle load-use stall. Without it, ID stalls on any
// producer still in EX or MEM; results are identical, only slower.
module mips32_pipe_core #(
  parameter int XLEN     = 32,
  parameter int PC_W     = 10,
  parameter int RESET_PC = 0
) (
  input  logic            clk,
  input  logic            rst,
  output logic [PC_W-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  output logic [PC_W-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  output logic            dmem_we,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            halted,
  output logic            illegal,
  output logic [31:0]     instret
);
  localparam logic [5:0] OP_ADD = 6'b000000, OP_SUB = 6'b000001, OP_AND = 6'b000010,
                         OP_OR  = 6'b000011, OP_SLT = 6'b000100, OP_MUL = 6'b000101,
                         OP_LW  = 6'b001000, OP_SW  = 6'b001001, OP_ADDI = 6'b001010,
                         OP_SUBI = 6'b001011, OP_SLTI = 6'b001100, OP_BNEQZ = 6'b001101,
                         OP_BEQZ = 6'b001110, OP_HLT = 6'b111111;

  typedef struct packed {
    logic v; logic [31:0] ir; logic [PC_W-1:0] npc;
  } ifid_t;
  typedef struct packed {
    logic v; logic [5:0] op; logic wr; logic halt; logic ill; logic [4:0] dest;
`ifdef PIPE_FWD_EN
    logic [4:0] rs; logic [4:0] rt;
`endif
    logic [XLEN-1:0] a; logic [XLEN-1:0] b; logic [XLEN-1:0] imm; logic [PC_W-1:0] npc;
  } idex_t;
  typedef struct packed {
    logic v; logic is_lw; logic is_sw; logic wr; logic halt; logic ill; logic [4:0] dest;
    logic [XLEN-1:0] alu; logic [XLEN-1:0] sd;
  } exmem_t;
  typedef struct packed {
    logic v; logic wr; logic halt; logic ill; logic [4:0] dest; logic [XLEN-1:0] res;
  } memwb_t;

  logic [PC_W-1:0] pc_q, pc_d;
  ifid_t  ifid_q, ifid_d;
  idex_t  idex_q, idex_d;
  exmem_t exmem_q, exmem_d;
  memwb_t memwb_q, memwb_d;
  logic   stop_q, stop_d, halted_q, halted_d, illegal_q, illegal_d;
  logic [31:0]     instret_q, instret_d;
  logic [XLEN-1:0] rf_q [32];
  logic [XLEN-1:0] rf_d [32];

  logic [5:0] id_op;
  logic [4:0] id_rs, id_rt, id_rd, id_dest;
  logic id_r, id_i, id_lw, id_sw, id_br, id_hlt, id_ill, id_use_rs, id_use_rt, id_wr;
  logic [XLEN-1:0] id_a, id_b, ex_a, ex_b, ex_op2, ex_alu;
  logic wb_we, hazard, flush, hlt_id;

  assign wb_we = memwb_q.v && memwb_q.wr && !halted_q;

  // Register file next state; r0 is never a write destination (wr excludes it).
  genvar gi;
  generate
    for (gi = 0; gi < 32; gi++) begin : g_rf
      assign rf_d[gi] = (wb_we && memwb_q.dest == 5'(gi)) ? memwb_q.res : rf_q[gi];
    end
  endgenerate

  // ID: decode, register read with same-cycle write-back bypass, hazard check.
  always_comb begin
    id_op     = ifid_q.ir[31:26];
    id_rs     = ifid_q.ir[25:21];
    id_rt     = ifid_q.ir[20:16];
    id_rd     = ifid_q.ir[15:11];
    id_r      = (id_op <= OP_MUL);
    id_i      = (id_op == OP_ADDI) || (id_op == OP_SUBI) || (id_op == OP_SLTI);
    id_lw     = (id_op == OP_LW);
    id_sw     = (id_op == OP_SW);
    id_br     = (id_op == OP_BNEQZ) || (id_op == OP_BEQZ);
    id_hlt    = (id_op == OP_HLT);
    id_ill    = !(id_r || id_i || id_lw || id_sw || id_br || id_hlt);
    id_use_rs = !(id_hlt || id_ill);
    id_use_rt = id_r || id_sw;
    id_dest   = id_r ? id_rd : id_rt;
    id_wr     = (id_r || id_i || id_lw) && (id_dest != 5'd0);
    id_a      = (id_rs == 5'd0) ? '0 :
                (wb_we && memwb_q.dest == id_rs) ? memwb_q.res : rf_q[id_rs];
    id_b      = (id_rt == 5'd0) ? '0 :
                (wb_we && memwb_q.dest == id_rt) ? memwb_q.res : rf_q[id_rt];
    hlt_id    = ifid_q.v && (id_hlt || id_ill);
`ifdef PIPE_FWD_EN
    // Only a load sitting in EX cannot be forwarded in time.
    hazard = ifid_q.v && idex_q.v && idex_q.op == OP_LW && idex_q.wr &&
             ((id_use_rs && id_rs == idex_q.dest) || (id_use_rt && id_rt == idex_q.dest));
`else
    hazard = ifid_q.v &&
             ((idex_q.v && idex_q.wr &&
               ((id_use_rs && id_rs == idex_q.dest) || (id_use_rt && id_rt == idex_q.dest))) ||
              (exmem_q.v && exmem_q.wr &&
               ((id_use_rs && id_rs == exmem_q.dest) || (id_use_rt && id_rt == exmem_q.dest))));
`endif
  end

  // EX: operand selection, ALU, branch resolution.
  always_comb begin
    ex_a = idex_q.a;
    ex_b = idex_q.b;
`ifdef PIPE_FWD_EN
    if (exmem_q.v && exmem_q.wr && !exmem_q.is_lw && exmem_q.dest == idex_q.rs) ex_a = exmem_q.alu;
    else if (memwb_q.v && memwb_q.wr && memwb_q.dest == idex_q.rs)               ex_a = memwb_q.res;
    if (exmem_q.v && exmem_q.wr && !exmem_q.is_lw && exmem_q.dest == idex_q.rt) ex_b = exmem_q.alu;
    else if (memwb_q.v && memwb_q.wr && memwb_q.dest == idex_q.rt)               ex_b = memwb_q.res;
`endif
    ex_op2 = (idex_q.op <= OP_MUL) ? ex_b : idex_q.imm;
    unique case (idex_q.op)
      OP_ADD, OP_ADDI, OP_LW, OP_SW: ex_alu = ex_a + ex_op2;
      OP_SUB, OP_SUBI:               ex_alu = ex_a - ex_op2;
      OP_AND:                        ex_alu = ex_a & ex_op2;
      OP_OR:                         ex_alu = ex_a | ex_op2;
      OP_SLT, OP_SLTI:               ex_alu = XLEN'($signed(ex_a) < $signed(ex_op2));
      OP_MUL:                        ex_alu = ex_a * ex_op2;
      default:                       ex_alu = '0;
    endcase
    flush = !halted_q && idex_q.v &&
            ((idex_q.op == OP_BEQZ && ex_a == '0) || (idex_q.op == OP_BNEQZ && ex_a != '0));
  end

  // Next state. A retired HLT freezes everything; a taken branch beats a stall.
  always_comb begin
    pc_d      = pc_q;
    ifid_d    = ifid_q;
    idex_d    = idex_q;
    exmem_d   = exmem_q;
    memwb_d   = memwb_q;
    stop_d    = stop_q;
    halted_d  = halted_q;
    illegal_d = illegal_q;
    instret_d = instret_q;
    if (!halted_q) begin
      if (flush) begin
        pc_d     = idex_q.npc + idex_q.imm[PC_W-1:0];
        ifid_d.v = 1'b0;
        idex_d.v = 1'b0;
      end else if (hazard) begin
        idex_d.v = 1'b0;
      end else begin
        if (hlt_id || stop_q) begin
          ifid_d.v = 1'b0;          // fetch frozen behind HLT/illegal
          stop_d   = 1'b1;
        end else begin
          pc_d   = pc_q + PC_W'(1);
          ifid_d = '{v: 1'b1, ir: imem_rdata, npc: pc_q + PC_W'(1)};
        end
        idex_d.v    = ifid_q.v;
        idex_d.op   = id_op;
        idex_d.wr   = id_wr;
        idex_d.halt = id_hlt;
        idex_d.ill  = id_ill;
        idex_d.dest = id_dest;
`ifdef PIPE_FWD_EN
        idex_d.rs   = id_rs;
        idex_d.rt   = id_rt;
`endif
        idex_d.a    = id_a;
        idex_d.b    = id_b;
        idex_d.imm  = XLEN'($signed(ifid_q.ir[15:0]));
        idex_d.npc  = ifid_q.npc;
      end
      exmem_d = '{v: idex_q.v, is_lw: idex_q.op == OP_LW, is_sw: idex_q.op == OP_SW,
                  wr: idex_q.wr, halt: idex_q.halt, ill: idex_q.ill, dest: idex_q.dest,
                  alu: ex_alu, sd: ex_b};
      memwb_d = '{v: exmem_q.v, wr: exmem_q.wr, halt: exmem_q.halt, ill: exmem_q.ill,
                  dest: exmem_q.dest, res: exmem_q.is_lw ? dmem_rdata : exmem_q.alu};
      if (memwb_q.v) begin
        instret_d = instret_q + 32'd1;
        halted_d  = memwb_q.halt || memwb_q.ill;
        illegal_d = memwb_q.ill;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q      <= PC_W'(RESET_PC);
      ifid_q    <= '0;
      idex_q    <= '0;
      exmem_q   <= '0;
      memwb_q   <= '0;
      stop_q    <= 1'b0;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
      instret_q <= '0;
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else begin
      pc_q      <= pc_d;
      ifid_q    <= ifid_d;
      idex_q    <= idex_d;
      exmem_q   <= exmem_d;
      memwb_q   <= memwb_d;
      stop_q    <= stop_d;
      halted_q  <= halted_d;
      illegal_q <= illegal_d;
      instret_q <= instret_d;
      rf_q      <= rf_d;
    end
  end

  assign imem_addr  = pc_q;
  assign dmem_addr  = exmem_q.alu[PC_W-1:0];
  assign dmem_wdata = exmem_q.sd;
  assign dmem_we    = exmem_q.v && exmem_q.is_sw && !halted_q;
  assign halted     = halted_q;
  assign illegal    = illegal_q;
  assign instret    = instret_q;
endmodule

// File: tb/tb_mips32_pipe_core.sv
// Directed-program bench for mips32_pipe_core: each program is loaded while
// the core is held in reset, run until halted, then register file, data
// memory and status outputs are compared against hand-computed values.
module tb_mips32_pipe_core;
  localparam int XLEN = 32;
  localparam int PC_W = 10;
`ifdef PIPE_FWD_EN
  localparam int P1_CYC = 8;
  localparam int P2_CYC = 10;
`else
  localparam int P1_CYC = 10;
  localparam int P2_CYC = 13;
`endif
  localparam logic [5:0] ADD = 6'b000000, SUB = 6'b000001, AND_ = 6'b000010, OR_ = 6'b000011,
                         SLT = 6'b000100, MUL = 6'b000101, LW = 6'b001000, SW = 6'b001001,
                         ADDI = 6'b001010, SUBI = 6'b001011, SLTI = 6'b001100,
                         BNEQZ = 6'b001101, BEQZ = 6'b001110, HLT = 6'b111111;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [PC_W-1:0] imem_addr, dmem_addr;
  logic [31:0]     imem_rdata, instret;
  logic [XLEN-1:0] dmem_wdata, dmem_rdata;
  logic            dmem_we, halted, illegal;
  logic            dmem_clr = 1'b0;

  logic [31:0]     imem [1024];
  logic [XLEN-1:0] dmem [1024];

  int checks = 0;
  int errors = 0;
  int cyc;
  logic [31:0] prog [$];

  mips32_pipe_core #(.XLEN(XLEN), .PC_W(PC_W), .RESET_PC(0)) dut (
    .clk(clk), .rst(rst),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_we(dmem_we), .dmem_rdata(dmem_rdata),
    .halted(halted), .illegal(illegal), .instret(instret)
  );

  always #5 clk = ~clk;

  assign imem_rdata = imem[imem_addr];
  assign dmem_rdata = dmem[dmem_addr];

  always @(posedge clk) begin
    if (dmem_clr) begin
      for (int i = 0; i < 1024; i++) dmem[i] <= '0;
    end else if (dmem_we) begin
      dmem[dmem_addr] <= dmem_wdata;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(input logic [5:0] op, input logic [4:0] rd,
                                        input logic [4:0] rs, input logic [4:0] rt);
    return {op, rs, rt, rd, 11'd0};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rt,
                                        input logic [4:0] rs, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  // Hold reset, load program (rest of imem = HLT), clear dmem, release at a negedge.
  task automatic start_prog(input logic [31:0] p [$]);
    rst = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 1024; i++) imem[i] = {HLT, 26'd0};
    foreach (p[i]) imem[i] = p[i];
    dmem_clr = 1'b1;
    @(negedge clk);
    dmem_clr = 1'b0;
    rst = 1'b0;
  endtask

  // Count rising edges after release until halted is seen (bounded).
  task automatic run_to_halt(input string tag, output int n);
    n = 0;
    while (!halted && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({tag, "_halted"}, 64'(halted), 64'd1);
    $display("prog %s: halted after %0d cycles, instret %0d", tag, n, instret);
  endtask

  initial begin
    // Reset state.
    prog = '{enc_i(ADDI, 5'd1, 5'd0, 16'd10)};
    rst = 1'b1;
    @(negedge clk);
    chk("rst_pc", 64'(imem_addr), 64'd0);
    chk("rst_halted", 64'(halted), 64'd0);
    chk("rst_illegal", 64'(illegal), 64'd0);
    chk("rst_instret", 64'(instret), 64'd0);
    chk("rst_dmem_we", 64'(dmem_we), 64'd0);

    // P1: simple dependency chain.
    prog = '{enc_i(ADDI, 5'd1, 5'd0, 16'd10), enc_i(ADDI, 5'd2, 5'd0, 16'd20),
             enc_r(ADD, 5'd3, 5'd1, 5'd2), {HLT, 26'd0}};
    start_prog(prog);
    run_to_halt("p1", cyc);
    chk("p1_cycles", 64'(cyc), 64'(P1_CYC));
    chk("p1_r3", 64'(dut.rf_q[3]), 64'd30);
    chk("p1_instret", 64'(instret), 64'd4);
    chk("p1_illegal", 64'(illegal), 64'd0);

    // P2: store, load, load-use.
    prog = '{enc_i(ADDI, 5'd3, 5'd0, 16'd30), enc_i(SW, 5'd3, 5'd0, 16'd5),
             enc_i(LW, 5'd4, 5'd0, 16'd5), enc_r(ADD, 5'd5, 5'd4, 5'd4), {HLT, 26'd0}};
    start_prog(prog);
    run_to_halt("p2", cyc);
    chk("p2_cycles", 64'(cyc), 64'(P2_CYC));
    chk("p2_dmem5", 64'(dmem[5]), 64'd30);
    chk("p2_r4", 64'(dut.rf_q[4]), 64'd30);
    chk("p2_r5", 64'(dut.rf_q[5]), 64'd60);
    chk("p2_instret", 64'(instret), 64'd5);

    // P3: taken branch flushes two shadow instructions.
    prog = '{enc_i(ADDI, 5'd1, 5'd0, 16'd0), enc_i(BEQZ, 5'd0, 5'd1, 16'd2),
             enc_i(ADDI, 5'd6, 5'd0, 16'd1), enc_i(ADDI, 5'd6, 5'd0, 16'd2),
             enc_i(ADDI, 5'd7, 5'd0, 16'd3), {HLT, 26'd0}};
    start_prog(prog);
    run_to_halt("p3", cyc);
    chk("p3_r6", 64'(dut.rf_q[6]), 64'd0);
    chk("p3_r7", 64'(dut.rf_q[7]), 64'd3);
    chk("p3_instret", 64'(instret), 64'd4);

    // P4: factorial of 5, result also stored to dmem[7].
    prog = '{enc_i(ADDI, 5'd2, 5'd0, 16'd5), enc_i(ADDI, 5'd3, 5'd0, 16'd1),
             enc_r(MUL, 5'd3, 5'd3, 5'd2), enc_i(SUBI, 5'd2, 5'd2, 16'd1),
             enc_i(BNEQZ, 5'd0, 5'd2, 16'hFFFD), enc_i(SW, 5'd3, 5'd0, 16'd7), {HLT, 26'd0}};
    start_prog(prog);
    run_to_halt("p4", cyc);
    chk("p4_r3", 64'(dut.rf_q[3]), 64'd120);
    chk("p4_r2", 64'(dut.rf_q[2]), 64'd0);
    chk("p4_dmem7", 64'(dmem[7]), 64'd120);
    chk("p4_instret", 64'(instret), 64'd19);

    // P5: illegal opcode mid-program.
    prog = '{enc_i(ADDI, 5'd1, 5'd0, 16'd7), enc_i(ADDI, 5'd2, 5'd0, 16'd8),
             {6'b010101, 26'd0}, enc_i(ADDI, 5'd9, 5'd0, 16'd9), {HLT, 26'd0}};
    start_prog(prog);
    run_to_halt("p5", cyc);
    chk("p5_illegal", 64'(illegal), 64'd1);
    chk("p5_r1", 64'(dut.rf_q[1]), 64'd7);
    chk("p5_r2", 64'(dut.rf_q[2]), 64'd8);
    chk("p5_r9", 64'(dut.rf_q[9]), 64'd0);
    chk("p5_instret", 64'(instret), 64'd3);
    repeat (5) @(posedge clk);
    #1;
    chk("p5_instret_frozen", 64'(instret), 64'd3);

    // P6: ALU coverage (signed compares, logic ops, subtract).
    prog = '{enc_i(ADDI, 5'd1, 5'd0, 16'hFFFD), enc_i(ADDI, 5'd2, 5'd0, 16'd5),
             enc_r(SLT, 5'd3, 5'd1, 5'd2), enc_i(SLTI, 5'd4, 5'd2, 16'hFFFF),
             enc_r(AND_, 5'd5, 5'd1, 5'd2), enc_r(OR_, 5'd6, 5'd1, 5'd2),
             enc_r(SUB, 5'd7, 5'd2, 5'd1), enc_r(SLT, 5'd8, 5'd2, 5'd1), {HLT, 26'd0}};
    start_prog(prog);
    run_to_halt("p6", cyc);
    chk("p6_slt", 64'(dut.rf_q[3]), 64'd1);
    chk("p6_slti", 64'(dut.rf_q[4]), 64'd0);
    chk("p6_and", 64'(dut.rf_q[5]), 64'd5);
    chk("p6_or", 64'(dut.rf_q[6]), 64'hFFFF_FFFD);
    chk("p6_sub", 64'(dut.rf_q[7]), 64'd8);
    chk("p6_slt_rev", 64'(dut.rf_q[8]), 64'd0);
    chk("p6_instret", 64'(instret), 64'd9);

    // P7: asynchronous reset mid-loop, then a clean restart of the factorial.
    prog = '{enc_i(ADDI, 5'd2, 5'd0, 16'd5), enc_i(ADDI, 5'd3, 5'd0, 16'd1),
             enc_r(MUL, 5'd3, 5'd3, 5'd2), enc_i(SUBI, 5'd2, 5'd2, 16'd1),
             enc_i(BNEQZ, 5'd0, 5'd2, 16'hFFFD), enc_i(SW, 5'd3, 5'd0, 16'd7), {HLT, 26'd0}};
    start_prog(prog);
    repeat (12) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("p7_rst_pc", 64'(imem_addr), 64'd0);
    chk("p7_rst_instret", 64'(instret), 64'd0);
    chk("p7_rst_halted", 64'(halted), 64'd0);
    chk("p7_rst_dmem_we", 64'(dmem_we), 64'd0);
    chk("p7_rst_r3", 64'(dut.rf_q[3]), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    run_to_halt("p7", cyc);
    chk("p7_r3", 64'(dut.rf_q[3]), 64'd120);
    chk("p7_dmem7", 64'(dmem[7]), 64'd120);
    chk("p7_instret", 64'(instret), 64'd19);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
